decryption_dispatch: RTL and testbench
======================================

// Module: decryption_dispatch
// PURPOSE
// - Single-clock, parametrised front-end for NUM_CH external decryption engines.
// - Serialises MST_DWIDTH input words into SYS_DWIDTH symbols, routes them to the engine chosen by the SELECT register, and supplies per-channel keys.
// - Collects the selected engine's output in a show-ahead FIFO with ready/valid backpressure on both sides.
// - Locks the channel selection while any traffic is in flight.
// PARAMETERS
// - NUM_CH      3   number of engine channels (2..16)
// - MST_DWIDTH  32  input word width; integer multiple of SYS_DWIDTH
// - SYS_DWIDTH  8   symbol width
// - addr_witdth 8   register address width
// - reg_width   16  register data width
// - FIFO_DEPTH  8   output FIFO entries, power of 2, >= MST_DWIDTH/SYS_DWIDTH
// PORTS
// - clk         in   1                    system clock, all logic rising-edge
// - rst         in   1                    synchronous reset, active-high
// - data_i      in   MST_DWIDTH           input word
// - valid_i     in   1                    input word valid
// - ready_o     out  1                    input word accepted when valid_i&&ready_o
// - data_o      out  SYS_DWIDTH           FIFO head symbol
// - valid_o     out  1                    FIFO non-empty
// - ready_i     in   1                    sink pops head when valid_o&&ready_i
// - busy        out  1                    serialiser active | any eng_busy_i | FIFO non-empty
// - addr        in   addr_witdth          register address
// - read        in   1                    register read strobe
// - write       in   1                    register write strobe
// - wdata       in   reg_width            write data
// - rdata       out  reg_width            read data, valid while done=1
// - done        out  1                    1-cycle access-complete pulse
// - error       out  1                    1-cycle, coincident with done, on a failed access
// - eng_data_o  out  NUM_CH*SYS_DWIDTH    symbol to engines (same value on every slice)
// - eng_valid_o out  NUM_CH               one-hot symbol strobe, bit = SELECT
// - eng_key_o   out  NUM_CH*reg_width     per-channel key, slice k = KEY[k]
// - eng_busy_i  in   NUM_CH               engine busy flags
// - eng_data_i  in   NUM_CH*SYS_DWIDTH    engine output symbols
// - eng_valid_i in   NUM_CH               engine output strobes
// BEHAVIOUR
// - Reset values: all outputs 0 except ready_o=1; SELECT=0; KEY[*]=0; FIFO empty; STATUS.OVF=0.
// - Register map (R = MST_DWIDTH/SYS_DWIDTH):
//   - 0x00 SELECT, R/W, low clog2(NUM_CH) bits.
//   - 0x01 STATUS, RO: {fifo_level, OVF@bit0}. A read clears OVF.
//   - 0x10+k KEY[k], R/W, k < NUM_CH.
// - Access timing: strobe at cycle t -> done (and error if failed) at t+1, rdata valid at t+1, otherwise 0. A failed write changes no state.
// - error cases:
//   - unmapped address;
//   - read && write together;
//   - write to STATUS;
//   - SELECT write of a value >= NUM_CH;
//   - SELECT write while busy=1.
// - KEY writes while busy are permitted.
// - Serialiser FSM IDLE/SHIFT:
//   - IDLE: ready_o = (FIFO free entries >= R). On accept, latch the word and go to SHIFT with cnt=0.
//   - SHIFT: emit one symbol per cycle, most significant symbol first, eng_valid_o[SELECT]=1. After symbol R-1, go to IDLE.
//   - ready_o is 0 in SHIFT, so no back-to-back accepts; throughput is R+1 cycles per word.
// - Latency: accept at t -> first eng_valid_o at t+1.
// - Output path:
//   - Only eng_valid_i[SELECT] pushes eng_data_i slice SELECT. Strobes on other channels are ignored.
//   - Engine strobe at t -> valid_o at t+1.
// - FIFO boundaries:
//   - Push and pop together when full: both occur, level unchanged.
//   - Push when full without pop: symbol dropped, OVF set (sticky).
//   - Pop when empty: impossible, because valid_o=0.
//   - Push and pop together when empty: level becomes 1, data_o shows the pushed symbol next cycle.
// - Reset asserted mid-word: the serialiser aborts, the FIFO flushes and no further eng_valid_o is issued. Reset has priority over every strobe that cycle.
// STRUCTURE
// - decryption_pkg:
//   - register address localparams (REG_SELECT, REG_STATUS, REG_KEY_BASE);
//   - clog2 function;
//   - FSM state encoding.
// - Sub-module decryption_byte_fifo: width/depth parametrised, show-ahead, with level and overflow outputs. Everything else stays in this module.
// TESTING
// - Reset, then read 0x00, 0x01, 0x10: rdata=0, done pulses, error=0; ready_o=1, valid_o=0.
// - Write KEY[1]=0x0305 and SELECT=1, then send data_i=0x41424344: eng_valid_o=3'b010 for 4 cycles carrying 0x41,0x42,0x43,0x44; eng_key_o slice 1 = 0x0305.
// - Engine 1 returns 0x61..0x64 with ready_i=0 for 10 cycles: valid_o=1, data_o=0x61 held; then ready_i=1 drains in order; busy drops after the last pop.
// - SELECT write of 2 while busy, of 3 with NUM_CH=3, and at addr 0x7F: each gives error=1 with done; a following SELECT read returns 1.
// - ready_i=0, push 9 symbols into the depth-8 FIFO: 9th dropped, STATUS=0x0081 (level 8, OVF=1), second read shows OVF=0.
// - rst at the second SHIFT cycle: no further eng_valid_o, valid_o=0 and ready_o=1 next cycle.

Source files
------------

// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption dispatch front-end.
// Holds the register map addresses, the serialiser state encoding and a
// constant-evaluable clog2 helper used for parameter-derived widths.
package decryption_pkg;

    // Register map (byte addresses on the configuration bus)
    localparam logic [7:0] REG_SELECT   = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h01;
    localparam logic [7:0] REG_KEY_BASE = 8'h10;

    // Bit position of the FIFO level field inside STATUS; bits below it
    // (except bit 0, the sticky overflow flag) read as zero.
    localparam int STATUS_LVL_LSB = 4;

    // Serialiser states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Ceiling log2, usable in parameter/localparam expressions
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem / 32'sd2;
        end
        return result;
    endfunction

endpackage

// File: rtl/decryption_byte_fifo.sv
// Show-ahead FIFO for engine output symbols.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes contents)
//   push          write request; accepted when not full, or when full and
//                 a pop happens in the same cycle
//   push_data     symbol to write
//   pop           read request; ignored while empty
//   pop_data      head symbol (zero while empty)
//   not_empty     head symbol is valid
//   level         number of stored entries (0..DEPTH)
//   overflow      1-cycle pulse when a push is dropped because full
module decryption_byte_fifo
    import decryption_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      not_empty,
    output logic [clog2(DEPTH):0]     level,
    output logic                      overflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;

    logic full_s;
    logic empty_s;
    logic do_push_s;
    logic do_pop_s;

    // Occupancy flags and effective push/pop; a full FIFO still takes a push when a pop frees a slot
    always_comb begin
        full_s    = (level_r == LVL_W'(DEPTH));
        empty_s   = (level_r == {LVL_W{1'b0}});
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
        overflow  = push && full_s && !do_pop_s;
    end

    // Pointer and level bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        if (empty_s) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r];
        end
        not_empty = !empty_s;
        level     = level_r;
    end

endmodule

// File: rtl/decryption_dispatch.sv
// Front-end for NUM_CH external decryption engines.
// Accepts MST_DWIDTH words, serialises them most-significant symbol first
// towards the engine chosen by SELECT, supplies per-channel keys and
// collects the selected engine's output symbols in a show-ahead FIFO.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   data_i/valid_i/ready_o       input word handshake
//   data_o/valid_o/ready_i       output symbol handshake (FIFO head)
//   busy                         serialiser active, engine busy or FIFO non-empty
//   addr/read/write/wdata        register access request
//   rdata/done/error             registered access response (one cycle later)
//   eng_data_o/eng_valid_o       symbol and one-hot strobe towards engines
//   eng_key_o                    per-channel keys
//   eng_busy_i/eng_data_i/eng_valid_i  engine status and returned symbols
module decryption_dispatch
    import decryption_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int MST_DWIDTH  = 32,
    parameter int SYS_DWIDTH  = 8,
    parameter int addr_witdth = 8,
    parameter int reg_width   = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MST_DWIDTH-1:0]         data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [SYS_DWIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          busy,
    input  logic [addr_witdth-1:0]        addr,
    input  logic                          read,
    input  logic                          write,
    input  logic [reg_width-1:0]          wdata,
    output logic [reg_width-1:0]          rdata,
    output logic                          done,
    output logic                          error,
    output logic [NUM_CH*SYS_DWIDTH-1:0]  eng_data_o,
    output logic [NUM_CH-1:0]             eng_valid_o,
    output logic [NUM_CH*reg_width-1:0]   eng_key_o,
    input  logic [NUM_CH-1:0]             eng_busy_i,
    input  logic [NUM_CH*SYS_DWIDTH-1:0]  eng_data_i,
    input  logic [NUM_CH-1:0]             eng_valid_i
);

    localparam int R     = MST_DWIDTH / SYS_DWIDTH;
    localparam int SEL_W = clog2(NUM_CH);
    localparam int LVL_W = clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = (R > 1) ? clog2(R) : 1;

    // Serialiser state
    ser_state_e              state_r;
    ser_state_e              state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [MST_DWIDTH-1:0]   sreg_r;
    logic                    accept_s;
    logic                    ready_s;

    // Configuration registers and access response
    logic [SEL_W-1:0]        select_r;
    logic [reg_width-1:0]    key_r [NUM_CH];
    logic                    ovf_r;
    logic                    done_r;
    logic                    error_r;
    logic [reg_width-1:0]    rdata_r;

    // Access decode
    logic                    sel_hit_s;
    logic                    stat_hit_s;
    logic                    key_hit_s;
    logic [addr_witdth-1:0]  key_off_s;
    logic [SEL_W-1:0]        key_idx_s;
    logic                    err_s;
    logic [reg_width-1:0]    rd_val_s;
    logic [reg_width-1:0]    status_s;

    // Output path
    logic                    push_s;
    logic [SYS_DWIDTH-1:0]   push_data_s;
    logic                    fifo_not_empty_s;
    logic                    fifo_ovf_s;
    logic [LVL_W-1:0]        fifo_level_s;
    logic [LVL_W-1:0]        fifo_free_s;
    logic                    busy_s;

    decryption_byte_fifo #(
        .WIDTH (SYS_DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (ready_i),
        .pop_data  (data_o),
        .not_empty (fifo_not_empty_s),
        .level     (fifo_level_s),
        .overflow  (fifo_ovf_s)
    );

    // Word acceptance: only from IDLE and only when a whole word's worth of results fits
    always_comb begin
        fifo_free_s = LVL_W'(FIFO_DEPTH) - fifo_level_s;
        if ((state_r == ST_IDLE) && (fifo_free_s >= LVL_W'(R))) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = valid_i && ready_s;
        busy_s   = (state_r == ST_SHIFT) || (|eng_busy_i) || fifo_not_empty_s;
    end

    // Serialiser next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(R - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Serialiser state, symbol counter and shift register (top symbol is the one on the bus)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            sreg_r  <= {MST_DWIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                sreg_r <= data_i;
                cnt_r  <= {CNT_W{1'b0}};
            end else if (state_r == ST_SHIFT) begin
                sreg_r <= sreg_r << SYS_DWIDTH;
                cnt_r  <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Engine-facing symbol bus, strobe, keys, and selection of the returning channel
    always_comb begin
        eng_data_o  = {NUM_CH{sreg_r[MST_DWIDTH-1 -: SYS_DWIDTH]}};
        eng_valid_o = {NUM_CH{1'b0}};
        eng_key_o   = {(NUM_CH*reg_width){1'b0}};
        push_s      = 1'b0;
        push_data_s = {SYS_DWIDTH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            eng_valid_o[k] = (state_r == ST_SHIFT) && (k == int'(select_r));
            eng_key_o[k*reg_width +: reg_width] = key_r[k];
            push_s = push_s | (eng_valid_i[k] && (k == int'(select_r)));
            push_data_s = push_data_s |
                (eng_data_i[k*SYS_DWIDTH +: SYS_DWIDTH] & {SYS_DWIDTH{k == int'(select_r)}});
        end
    end

    // Register access decode, error classification and read mux
    always_comb begin
        sel_hit_s  = (addr == addr_witdth'(REG_SELECT));
        stat_hit_s = (addr == addr_witdth'(REG_STATUS));
        key_off_s  = addr - addr_witdth'(REG_KEY_BASE);
        key_hit_s  = (addr >= addr_witdth'(REG_KEY_BASE)) && (key_off_s < addr_witdth'(NUM_CH));
        key_idx_s  = key_off_s[SEL_W-1:0];

        status_s = {reg_width{1'b0}};
        status_s[0] = ovf_r;
        status_s[STATUS_LVL_LSB +: LVL_W] = fifo_level_s;

        err_s = 1'b0;
        if (read && write) begin
            err_s = 1'b1;
        end else if (!(sel_hit_s || stat_hit_s || key_hit_s)) begin
            err_s = 1'b1;
        end else if (write && stat_hit_s) begin
            err_s = 1'b1;
        end else if (write && sel_hit_s && ((wdata >= reg_width'(NUM_CH)) || busy_s)) begin
            // SELECT is frozen while anything is in flight
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end

        rd_val_s = {reg_width{1'b0}};
        if (sel_hit_s) begin
            rd_val_s = reg_width'(select_r);
        end else if (stat_hit_s) begin
            rd_val_s = status_s;
        end else if (key_hit_s) begin
            rd_val_s = key_r[key_idx_s];
        end else begin
            rd_val_s = {reg_width{1'b0}};
        end
    end

    // Configuration registers, sticky overflow and registered access response
    always_ff @(posedge clk) begin
        if (rst) begin
            select_r <= {SEL_W{1'b0}};
            for (int k = 0; k < NUM_CH; k++) begin
                key_r[k] <= {reg_width{1'b0}};
            end
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            rdata_r <= {reg_width{1'b0}};
        end else begin
            done_r  <= read || write;
            error_r <= (read || write) && err_s;
            if (read && !err_s) begin
                rdata_r <= rd_val_s;
            end else begin
                rdata_r <= {reg_width{1'b0}};
            end
            if (write && !err_s && sel_hit_s) begin
                select_r <= wdata[SEL_W-1:0];
            end
            if (write && !err_s && key_hit_s) begin
                key_r[key_idx_s] <= wdata;
            end
            // A new drop wins over a clearing read so the event is never lost
            if (fifo_ovf_s) begin
                ovf_r <= 1'b1;
            end else if (read && !err_s && stat_hit_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign ready_o = ready_s;
    assign valid_o = fifo_not_empty_s;
    assign busy    = busy_s;
    assign rdata   = rdata_r;
    assign done    = done_r;
    assign error   = error_r;

endmodule

// File: tb/tb_decryption_dispatch.sv
// Self-checking bench for decryption_dispatch: table of register accesses
// followed by directed sequences for streaming, backpressure, overflow and
// mid-word reset.
module tb_decryption_dispatch;

    localparam int NUM_CH = 3;
    localparam int MW     = 32;
    localparam int SW     = 8;
    localparam int AW     = 8;
    localparam int RW     = 16;
    localparam int DEPTH  = 8;

    logic                 clk;
    logic                 rst;
    logic [MW-1:0]        data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [SW-1:0]        data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 busy;
    logic [AW-1:0]        addr;
    logic                 read;
    logic                 write;
    logic [RW-1:0]        wdata;
    logic [RW-1:0]        rdata;
    logic                 done;
    logic                 error;
    logic [NUM_CH*SW-1:0] eng_data_o;
    logic [NUM_CH-1:0]    eng_valid_o;
    logic [NUM_CH*RW-1:0] eng_key_o;
    logic [NUM_CH-1:0]    eng_busy_i;
    logic [NUM_CH*SW-1:0] eng_data_i;
    logic [NUM_CH-1:0]    eng_valid_i;

    int checks = 0;
    int errors = 0;

    decryption_dispatch #(
        .NUM_CH(NUM_CH), .MST_DWIDTH(MW), .SYS_DWIDTH(SW),
        .addr_witdth(AW), .reg_width(RW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy(busy),
        .addr(addr), .read(read), .write(write), .wdata(wdata),
        .rdata(rdata), .done(done), .error(error),
        .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o), .eng_key_o(eng_key_o),
        .eng_busy_i(eng_busy_i), .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rd;
        logic          wr;
        logic [7:0]    a;
        logic [15:0]   wd;
        logic [15:0]   exp_rdata;
        logic          exp_err;
    } reg_vec_t;

    reg_vec_t tbl [16];

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One register access; response is checked one cycle after the strobe
    task automatic reg_acc(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [15:0] wd, input logic [15:0] exp_rdata,
                           input logic exp_err, input string name);
        read  = rd;
        write = wr;
        addr  = a;
        wdata = wd;
        step();
        read  = 1'b0;
        write = 1'b0;
        check({name, ".done"},  64'(done), 64'd1);
        check({name, ".error"}, 64'(error), 64'(exp_err));
        check({name, ".rdata"}, 64'(rdata), 64'(exp_rdata));
    endtask

    // Wait (bounded) for ready_o, then present one word for a single cycle
    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 50 && !ready_o; i++) begin
            step();
        end
        check("send.ready_wait", 64'(ready_o), 64'd1);
        data_i  = w;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    // Push one symbol on the given engine channel mask
    task automatic eng_push(input logic [2:0] vmask, input logic [7:0] sym);
        eng_valid_i = vmask;
        eng_data_i  = {sym, sym, sym};
        step();
        eng_valid_i = 3'b000;
    endtask

    initial begin
        logic [7:0] exp_sym;

        rst = 1'b1; data_i = '0; valid_i = 1'b0; ready_i = 1'b0;
        addr = '0; read = 1'b0; write = 1'b0; wdata = '0;
        eng_busy_i = '0; eng_data_i = '0; eng_valid_i = '0;

        // Reset state
        step();
        step();
        check("rst.ready_o", 64'(ready_o), 64'd1);
        check("rst.valid_o", 64'(valid_o), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.eng_valid_o", 64'(eng_valid_o), 64'd0);
        check("rst.eng_key_o", 64'(eng_key_o), 64'd0);
        rst = 1'b0;

        // Register access table (nothing in flight, so SELECT writes are allowed)
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h01, 16'h0000, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h11, 16'h0305, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 16'h0001, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h11, 16'h0000, 16'h0305, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h01, 16'h0005, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'h13, 16'h0000, 16'h0000, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 16'h0003, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 8'h00, 16'h0002, 16'h0000, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 16'h0000, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h7F, 16'h0000, 16'h0000, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 8'h01, 16'h0000, 16'h0000, 1'b0};
        for (int i = 0; i < 16; i++) begin
            reg_acc(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd,
                    tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("tbl%0d", i));
        end
        step();
        check("done.pulse_end", 64'(done), 64'd0);
        check("keys", 64'(eng_key_o), {16'h0, 48'hBEEF_0305_0000});

        // Serialise one word to engine 1, MS symbol first
        send_word(32'h41424344);
        for (int i = 0; i < 4; i++) begin
            exp_sym = 8'h41 + 8'(i);
            check($sformatf("ser%0d.eng_valid_o", i), 64'(eng_valid_o), 64'h2);
            check($sformatf("ser%0d.eng_data_o", i), 64'(eng_data_o), 64'({exp_sym, exp_sym, exp_sym}));
            check($sformatf("ser%0d.ready_o", i), 64'(ready_o), 64'd0);
            step();
        end
        check("ser.end.eng_valid_o", 64'(eng_valid_o), 64'd0);
        check("ser.end.ready_o", 64'(ready_o), 64'd1);

        // Engine 1 returns four symbols; a channel-0 strobe on one cycle is ignored
        for (int i = 0; i < 4; i++) begin
            eng_push((i == 1) ? 3'b011 : 3'b010, 8'h61 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            check("hold.valid_o", 64'(valid_o), 64'd1);
            check("hold.data_o", 64'(data_o), 64'h61);
            step();
        end
        check("hold.busy", 64'(busy), 64'd1);
        check("hold.ready_o", 64'(ready_o), 64'd1);
        reg_acc(1'b1, 1'b0, 8'h01, 16'h0, 16'h0040, 1'b0, "status.level4");
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain.valid_o", 64'(valid_o), 64'd1);
            check("drain.data_o", 64'(data_o), 64'(8'h61 + 8'(i)));
            step();
        end
        ready_i = 1'b0;
        check("drain.end.valid_o", 64'(valid_o), 64'd0);
        check("drain.end.busy", 64'(busy), 64'd0);

        // SELECT locked while busy; KEY writes still allowed
        eng_busy_i = 3'b100;
        #1;
        check("lock.busy", 64'(busy), 64'd1);
        reg_acc(1'b0, 1'b1, 8'h00, 16'h0002, 16'h0, 1'b1, "lock.sel2");
        reg_acc(1'b0, 1'b1, 8'h00, 16'h0003, 16'h0, 1'b1, "lock.sel3");
        reg_acc(1'b0, 1'b1, 8'h7F, 16'h0001, 16'h0, 1'b1, "lock.addr7f");
        reg_acc(1'b0, 1'b1, 8'h10, 16'h1234, 16'h0, 1'b0, "lock.key0");
        eng_busy_i = 3'b000;
        reg_acc(1'b1, 1'b0, 8'h00, 16'h0, 16'h0001, 1'b0, "lock.sel_rd");
        reg_acc(1'b1, 1'b0, 8'h10, 16'h0, 16'h1234, 1'b0, "lock.key0_rd");

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) begin
            eng_push(3'b010, 8'hA0 + 8'(i));
        end
        check("ovf.ready_o", 64'(ready_o), 64'd0);
        check("ovf.data_o", 64'(data_o), 64'hA0);
        reg_acc(1'b1, 1'b0, 8'h01, 16'h0, 16'h0081, 1'b0, "ovf.status1");
        reg_acc(1'b1, 1'b0, 8'h01, 16'h0, 16'h0080, 1'b0, "ovf.status2");

        // Push and pop together while full: both happen, level unchanged
        ready_i = 1'b1;
        eng_push(3'b010, 8'hB0);
        ready_i = 1'b0;
        check("fullpp.data_o", 64'(data_o), 64'hA1);
        reg_acc(1'b1, 1'b0, 8'h01, 16'h0, 16'h0080, 1'b0, "fullpp.status");
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_sym = (i < 7) ? (8'hA1 + 8'(i)) : 8'hB0;
            check("fulldrain.data_o", 64'(data_o), 64'(exp_sym));
            step();
        end
        check("fulldrain.valid_o", 64'(valid_o), 64'd0);

        // Push into empty FIFO while the sink is ready
        eng_push(3'b010, 8'hC5);
        check("emptypush.valid_o", 64'(valid_o), 64'd1);
        check("emptypush.data_o", 64'(data_o), 64'hC5);
        step();
        check("emptypush.popped", 64'(valid_o), 64'd0);
        ready_i = 1'b0;

        // Reset during the second SHIFT cycle, with strobes that reset must override
        eng_push(3'b010, 8'h77);
        send_word(32'h11223344);
        check("rstmid.first", 64'(eng_data_o[7:0]), 64'h11);
        step();
        check("rstmid.second.valid", 64'(eng_valid_o), 64'h2);
        check("rstmid.second.data", 64'(eng_data_o[7:0]), 64'h22);
        rst     = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'hDEADBEEF;
        write   = 1'b1;
        addr    = 8'h00;
        wdata   = 16'h0002;
        step();
        rst     = 1'b0;
        valid_i = 1'b0;
        write   = 1'b0;
        check("rstmid.eng_valid_o", 64'(eng_valid_o), 64'd0);
        check("rstmid.valid_o", 64'(valid_o), 64'd0);
        check("rstmid.ready_o", 64'(ready_o), 64'd1);
        check("rstmid.done", 64'(done), 64'd0);
        check("rstmid.busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rstmid.quiet", 64'(eng_valid_o), 64'd0);
        end
        reg_acc(1'b1, 1'b0, 8'h00, 16'h0, 16'h0000, 1'b0, "rstmid.sel");
        reg_acc(1'b1, 1'b0, 8'h11, 16'h0, 16'h0000, 1'b0, "rstmid.key1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
